// File: rtl/div16_pkg.sv
// Shared encodings, widths and helpers for the iterative 16-bit divider.
package div16_pkg;
  localparam int W  = 16;
  localparam int CW = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [W-1:0] DIV0_QUOTIENT = 16'hFFFF;

  function automatic logic [W-1:0] neg_if(input logic [W-1:0] x, input logic en);
    return en ? -x : x;
  endfunction
endpackage

// File: rtl/clz16.sv
// Count of leading zeros of a 16-bit value; an all-zero input yields 16.
module clz16
  import div16_pkg::*;
(
  input  logic [W-1:0]  val_i,
  output logic [CW-1:0] cnt_o
);
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (val_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end
endmodule

// File: rtl/div16_seq.sv
// Iterative unsigned divider, one quotient bit per clock, divisor pre-normalised via clz16.
// Define DIV16_SIGNED_EN to add the signed_op input (truncating signed division).
module div16_seq
  import div16_pkg::*;
#(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
`ifdef DIV16_SIGNED_EN
  input  logic         signed_op,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_zero
);
  state_t        state_q;
  logic [W-1:0]  n_q, d_q, dsh_q, rem_q, qacc_q, quo_q, rmd_q;
  logic [3:0]    iter_q;
  logic          done_q, dz_q;

  logic [CW-1:0] lz_n, lz_d, k_wide, k_sel;
  logic [W-1:0]  a_mag, b_mag, rem_d, qacc_d;
  logic          n_lt_d, ge, flip_quo, flip_rem;

`ifdef DIV16_SIGNED_EN
  logic negq_q, negr_q;
  assign a_mag    = neg_if(dividend, signed_op & dividend[W-1]);
  assign b_mag    = neg_if(divisor, signed_op & divisor[W-1]);
  assign flip_quo = negq_q;
  assign flip_rem = negr_q;
`else
  assign a_mag    = dividend;
  assign b_mag    = divisor;
  assign flip_quo = 1'b0;
  assign flip_rem = 1'b0;
`endif

  clz16 u_clz_n (.val_i(n_q), .cnt_o(lz_n));
  clz16 u_clz_d (.val_i(d_q), .cnt_o(lz_d));

  // With n >= d the shift aligns the divisor MSB to the dividend MSB without loss.
  assign n_lt_d = n_q < d_q;
  assign k_wide = lz_d - lz_n;
  assign k_sel  = n_lt_d ? '0 : k_wide;

  assign ge     = rem_q >= dsh_q;
  assign rem_d  = ge ? rem_q - dsh_q : rem_q;
  assign qacc_d = (qacc_q << 1) | {{(W-1){1'b0}}, ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      d_q     <= '0;
      dsh_q   <= '0;
      rem_q   <= '0;
      qacc_q  <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      iter_q  <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef DIV16_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          n_q <= a_mag;
          d_q <= b_mag;
`ifdef DIV16_SIGNED_EN
          negq_q <= signed_op & (dividend[W-1] ^ divisor[W-1]);
          negr_q <= signed_op & dividend[W-1];
`endif
          if (divisor == '0) begin
            quo_q   <= DIV0_QUOTIENT;
            rmd_q   <= dividend;
            dz_q    <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            dz_q    <= 1'b0;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (EARLY_OUT && n_lt_d) begin
            quo_q   <= '0;
            rmd_q   <= neg_if(n_q, flip_rem);
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            dsh_q   <= d_q << k_sel;
            rem_q   <= n_q;
            qacc_q  <= '0;
            iter_q  <= k_sel[3:0];
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          rem_q  <= rem_d;
          qacc_q <= qacc_d;
          dsh_q  <= dsh_q >> 1;
          if (iter_q == 4'd0) begin
            quo_q   <= neg_if(qacc_d, flip_quo);
            rmd_q   <= neg_if(rem_d, flip_rem);
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            iter_q <= iter_q - 4'd1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign div_zero  = dz_q;
endmodule

// File: doc/div16_seq.md
Name: div16_seq

Overview:
- Iterative unsigned 16-bit divider, one quotient bit per clock.
- Consumes clz16 leading-zero counts of dividend and divisor to normalise the divisor, so the iteration count equals the number of significant quotient bits (1..16) rather than a fixed 16.
- Sits behind the ALU as a multi-cycle execution unit, started by the sequencer and returning quotient and remainder with a one-cycle done pulse.

Parameters:
- EARLY_OUT, 1, when 1 a dividend smaller than the divisor finishes straight from SETUP; when 0 it runs one RUN cycle (k=0) and gives the same result.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only while busy=0
- dividend  input  16  numerator, sampled on the accepting edge
- divisor  input  16  denominator, sampled on the accepting edge
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse; quotient, remainder and div_zero are valid in this cycle
- quotient  output  16  result; holds its value until the next accepted start
- remainder  output  16  result; holds its value until the next accepted start
- div_zero  output  1  divisor was 0 for the last operation; held with the result

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, all internal registers 0. Reset during any state aborts the operation and no done is produced.
- States: IDLE, SETUP, RUN, DONE. Let T be the cycle in which start=1 and state=IDLE.
- IDLE:
  - On start, latch n=dividend and d=divisor.
  - If d==0: quotient=16'hFFFF, remainder=n, div_zero=1, next state DONE (done at T+1).
  - Otherwise: div_zero=0, next state SETUP.
- SETUP:
  - Compute lz_n=clz16(n) and lz_d=clz16(d), each 5 bits.
  - If n<d and EARLY_OUT: quotient=0, remainder=n, next state DONE (done at T+2).
  - Otherwise: k=lz_d-lz_n (4 bits, 0..15), dsh=d<<k (16 bits, no loss), rem=n, q=0, iter=k, next state RUN.
  - With EARLY_OUT=0 and n<d, use k=0 (dsh=d).
- RUN, once per cycle:
  - If rem>=dsh: rem=rem-dsh and q={q[14:0],1}; otherwise q={q[14:0],0}.
  - Then dsh=dsh>>1.
  - If iter==0: latch quotient/remainder from the updated q/rem and go to DONE. Otherwise iter=iter-1.
  - RUN lasts k+1 cycles; done at T+3+k; worst case T+18.
- DONE: done=1 for exactly one cycle, busy=1, next state IDLE.
- start while busy=1 is ignored, including in the DONE cycle. start back-to-back in the first IDLE cycle after DONE is accepted.
- All comparisons and subtraction are unsigned 16-bit; rem never underflows.

Optional Feature:
- Macro DIV16_SIGNED_EN. When defined, add input signed_op (1 bit, sampled with start).
- With signed_op=1:
  - Operands are converted to magnitudes in IDLE.
  - On entry to DONE, the quotient is negated when the operand signs differ, and the remainder takes the dividend's sign (truncation toward zero).
  - Divide-by-zero returns quotient=16'hFFFF and remainder=dividend, unchanged.
  - 16'h8000 / 16'hFFFF returns quotient=16'h8000, remainder=0.
- Latency is identical with and without signed_op.
- Macro undefined: no signed_op port, unsigned only.

Decomposition:
- Package div16_pkg holds:
  - state encodings ST_IDLE, ST_SETUP, ST_RUN, ST_DONE (2 bits);
  - DIV0_QUOTIENT=16'hFFFF;
  - widths W=16 and CW=5.
- Sub-modules: two existing clz16 instances (dividend, divisor) fed from the latched n and d. No new sub-module.

Test Plan:
- 100/7 at T -> done at T+7 (k=4), quotient=14, remainder=2, div_zero=0; busy high T+1..T+7.
- 16'hFFFF/1 -> done at T+18 (k=15), quotient=16'hFFFF, remainder=0.
- 5/9 with EARLY_OUT=1 -> done at T+2, quotient=0, remainder=5; with EARLY_OUT=0 -> done at T+3, same result.
- 16'h1234/0 -> done at T+1, quotient=16'hFFFF, remainder=16'h1234, div_zero=1; then 10/3 -> div_zero=0, quotient=3, remainder=1.
- Start 1000/3, pulse start with 8/2 at T+3 (ignored), assert rst_n=0 at T+5 -> outputs 0, no done; after release, 8/2 -> quotient=4, remainder=0.
- DIV16_SIGNED_EN with signed_op=1, -7/2 -> quotient=16'hFFFD, remainder=16'hFFFF; 16'h8000/16'hFFFF -> quotient=16'h8000, remainder=0.
